// File: rtl/countdown_counter.sv
// countdown_counter: start-triggered down-counter.
// An accepted start in IDLE loads q with LOAD_VAL; q then decrements once per
// clock and the block returns to IDLE (ready=1) on the edge that takes q to 0.
// Optional feature macro: COUNTER_RETRIGGER_EN (start during COUNT reloads q).
module countdown_counter #(
    parameter int WIDTH    = 5,
    parameter int LOAD_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] LP_LOAD = WIDTH'(LOAD_VAL);
    localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;

    // State and count registers; reset forces IDLE with a zero count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
        end
    end

    // Next-state and next-count decode; the count leaves COUNT on the q==1 edge.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_q_nxt     = LP_LOAD;
                    w_state_nxt = S_COUNT;
                end else begin
                    w_q_nxt = '0;
                end
            end
            S_COUNT: begin
`ifdef COUNTER_RETRIGGER_EN
                if (start) begin
                    w_q_nxt = LP_LOAD;
                end else
`endif
                if (r_q > LP_ONE) begin
                    w_q_nxt = r_q - LP_ONE;
                end else begin
                    w_q_nxt     = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_q_nxt     = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from the registers; no path from start.
    assign ready = (r_state == S_IDLE);
    assign q     = r_q;

endmodule

// File: tb/tb_countdown_counter.sv
// Directed bench for countdown_counter (default WIDTH=5, LOAD_VAL=31).
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_countdown_counter;

    localparam int LV = 31;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic [4:0] q;

    int n_vec = 0;
    int n_err = 0;

    countdown_counter #(.WIDTH(5), .LOAD_VAL(LV)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ready (ready),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] exp_q, input logic exp_r);
        n_vec++;
        assert ({ready, q} === {exp_r, exp_q}) else begin
            n_err++;
            $error("FAIL %s: got q=%0d ready=%0b, expected q=%0d ready=%0b",
                   tag, q, ready, exp_q, exp_r);
        end
    endtask

    // Apply start for one clock, then check the outputs that result.
    task automatic step(input logic s, input string tag, input logic [4:0] exp_q,
                        input logic exp_r);
        start = s;
        @(negedge clk);
        chk(tag, exp_q, exp_r);
    endtask

    initial begin
        // Reset: active before any clock edge, held across the first edge
        rst   = 1'b1;
        start = 1'b0;
        #1 chk("reset_no_edge", 5'd0, 1'b1);
        #5 chk("reset_after_edge", 5'd0, 1'b1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_after_release", 5'd0, 1'b1);
        step(1'b0, "idle_hold", 5'd0, 1'b1);

        // start changing must not reach outputs before a clock edge
        start = 1'b1;
        #1 chk("start_no_comb_path", 5'd0, 1'b1);
        @(negedge clk);
        chk("basic_load", 5'(LV), 1'b0);

        // Basic count down to 0, with 31 cycles of ready=0
        for (int k = 1; k < LV; k++) step(1'b0, "basic_dec", 5'(LV - k), 1'b0);
        step(1'b0, "basic_done", 5'd0, 1'b1);
        step(1'b0, "basic_idle", 5'd0, 1'b1);

        // Reset mid-count at q=20
        step(1'b1, "mid_load", 5'(LV), 1'b0);
        for (int k = 1; k <= 11; k++) step(1'b0, "mid_dec", 5'(LV - k), 1'b0);
        #2 rst = 1'b1;
        #1 chk("mid_reset_async", 5'd0, 1'b1);
        @(negedge clk);
        chk("mid_reset_held", 5'd0, 1'b1);
        rst = 1'b0;
        step(1'b1, "post_reset_load", 5'(LV), 1'b0);
        for (int k = 1; k < LV; k++) step(1'b0, "post_reset_dec", 5'(LV - k), 1'b0);
        step(1'b0, "post_reset_done", 5'd0, 1'b1);

        // Held start for 4 cycles
`ifdef COUNTER_RETRIGGER_EN
        for (int k = 0; k < 4; k++) step(1'b1, "held_reload", 5'(LV), 1'b0);
        for (int k = 1; k < LV; k++) step(1'b0, "held_dec", 5'(LV - k), 1'b0);
        step(1'b0, "held_done", 5'd0, 1'b1);
`else
        for (int k = 0; k < 4; k++) step(1'b1, "held_ignored", 5'(LV - k), 1'b0);
        for (int k = 4; k < LV; k++) step(1'b0, "held_dec", 5'(LV - k), 1'b0);
        step(1'b0, "held_done", 5'd0, 1'b1);
`endif
        step(1'b0, "held_idle", 5'd0, 1'b1);

        // Start held high continuously
`ifdef COUNTER_RETRIGGER_EN
        for (int k = 0; k < 34; k++) step(1'b1, "b2b_reload", 5'(LV), 1'b0);
`else
        for (int k = 0; k < LV; k++) step(1'b1, "b2b_first", 5'(LV - k), 1'b0);
        step(1'b1, "b2b_gap", 5'd0, 1'b1);
        step(1'b1, "b2b_second_load", 5'(LV), 1'b0);
        step(1'b1, "b2b_second_dec", 5'(LV - 1), 1'b0);
`endif
        start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_counter.md
# countdown_counter

Start-triggered 5-bit down-counter: a start request in idle loads the counter with its maximum value. It then decrements once per clock to zero and signals `ready` when idle again. It is a self-contained timing element for sequencing logic that needs a fixed delay between a trigger and completion. The RTL module is named `countdown_counter`.

## Interface
- `WIDTH`, default 5: counter width in bits; sets the width of `q`.
- `LOAD_VAL`, default 2**WIDTH-1 (31): value loaded on an accepted start; must be nonzero and ≤ 2**WIDTH-1.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-high; forces idle.
- `start` input, 1 bit: level-sampled start request.
- `ready` output, 1 bit: high when idle (count complete, a new start is accepted).
- `q` output, `WIDTH` bits: current count value, driven directly from a register.

## Operation
- Two states: IDLE and COUNT. `ready` = (state == IDLE), decoded combinationally from the state register.
- Reset (`rst`=1, asynchronous): state=IDLE, `q`=0, `ready`=1. This holds for as long as `rst` is high, including when it is asserted mid-count.
- IDLE, `start`=0: hold `q`=0.
- IDLE, `start`=1 at a rising edge: `q` ← `LOAD_VAL`, state ← COUNT.
- COUNT, `q` > 1: `q` ← `q`−1.
- COUNT, `q` == 1: `q` ← 0, state ← IDLE.
- COUNT, `start`=1: ignored by default; see Configuration.
- `start` is level-sensitive, not edge-detected. If `start` is still high in the IDLE cycle after completion, a new count begins at the next edge, so a held `start` gives back-to-back counts with one IDLE cycle between them.
- Arithmetic is unsigned `WIDTH`-bit. `q` never wraps below 0 and never exceeds `LOAD_VAL`.
- `q` == 0 is equivalent to `ready` == 1 in all states.

## Timing
- Start accepted at rising edge N: after edge N, `q`=`LOAD_VAL` and `ready`=0.
- After edge N+k for 1 ≤ k < `LOAD_VAL`: `q`=`LOAD_VAL`−k.
- After edge N+`LOAD_VAL`: `q`=0 and `ready`=1. With defaults that is 31 cycles of `ready`=0.
- Earliest next accepted start: edge N+`LOAD_VAL`+1.
- Reset asserts combinationally and immediately; outputs take their reset values without waiting for a clock edge. Release is synchronous to the next edge: the first edge after `rst` falls can already accept `start`.
- No combinational path from `start` to any output.

## Configuration
- Macro `COUNTER_RETRIGGER_EN`.
- Undefined (default): `start` during COUNT is ignored and the count always runs to completion.
- Defined: `start`=1 at a rising edge during COUNT reloads `q` ← `LOAD_VAL` and stays in COUNT. This includes the `q`==1 edge, where the reload wins over completion. Completion therefore occurs `LOAD_VAL` edges after the last accepted start.

## Test plan
- Reset: `rst`=1 for 7 ns, with `clk` period 10 ns and `start`=0 → `q`=0 and `ready`=1 during and after reset, with no edges required.
- Basic count: release `rst`, pulse `start`=1 for one cycle at negedge → `q` goes 31, 30, …, 1, 0 on successive edges; `ready`=0 for exactly 31 cycles, then 1.
- Held start, macro undefined: `start`=1 for 4 cycles, then 0 → `q`=31, 30, 29, 28, … with no reload; `ready` rises 31 edges after the first accepting edge.
- Held start, macro defined: same stimulus → `q` stays 31 for 4 edges, then decrements; completion occurs 31 edges after the last high sample.
- Back-to-back: `start` held high continuously → `q` sequence 31…0, then one cycle of `q`=0 with `ready`=1, then 31 again; repeats.
- Reset mid-count: assert `rst` while `q`=20 → `q`=0 and `ready`=1 immediately. After release with `start`=1, `q`=31 at the next edge.
